// File: rtl/display_pkg.sv
// Shared types and constants for the display datapath.
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // Shown on every digit when the input cannot be represented.
  localparam bcd_digit_t OVF_NIBBLE     = 4'hE;
  // Double-dabble correction: digits at or above the threshold get +3 before the shift.
  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

  // 10**n as a 64-bit constant; used for the elaboration-time overflow limit.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit double-dabble correction: d >= 5 ? d + 3 : d.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t d_adj
);

  // Add-3 stays 4 bits wide; valid BCD inputs never exceed 9, so 12 is the largest result.
  always_comb begin
    d_adj = (d >= BCD_ADJ_THRESH) ? bcd_digit_t'(d + BCD_ADJ_ADD) : d;
  end

endmodule

// File: rtl/bin2bcd_display.sv
// Sequential binary to packed-BCD converter (double-dabble, one shift per clock).
// Results are registered and held between conversions so the downstream display
// never sees a partially converted value.
module bin2bcd_display
  import display_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 27,
  parameter int unsigned DIGITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   in_value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int unsigned     AccW     = 4 * DIGITS;
  localparam int unsigned     CntW     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLoad  = CntW'(IN_WIDTH - 1);
  localparam longint unsigned OvfLimit = pow10(DIGITS);

  bcd_state_t          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [AccW-1:0]     bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                busy_q;
  logic                done_q;

  logic [AccW-1:0]     acc_adj;
  logic [AccW-1:0]     acc_shift;
  logic [IN_WIDTH-1:0] bin_shift;
  logic [DIGITS-1:0]   blank_calc;
  logic                ovf_in;

  // Per-digit add-3 correction applied to the accumulator before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
    bcd_digit_adjust u_adj (
      .d     (acc_q[4*g +: 4]),
      .d_adj (acc_adj[4*g +: 4])
    );
  end

  // Overflow pre-check against a constant limit; guarantees no carry out of the top digit.
  always_comb begin
    ovf_in = (64'(in_value) >= OvfLimit);
  end

  // One double-dabble step: shift the adjusted accumulator and binary register left as one.
  always_comb begin
    acc_shift = {acc_adj[AccW-2:0], bin_q[IN_WIDTH-1]};
    bin_shift = {bin_q[IN_WIDTH-2:0], 1'b0};
  end

  // Leading-zero mask of the final step's result, scanning from the top digit down.
  always_comb begin
    logic zero_run;
    blank_calc = '0;
    zero_run   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run      = zero_run & (acc_shift[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_run;
    end
  end

  // FSM next-state and datapath loads; output registers load on the edge entering DONE,
  // so they are already valid during the done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d = in_value;
          acc_d = '0;
          cnt_d = CntLoad;
          if (ovf_in) begin
            state_d = DONE;
            bcd_d   = {DIGITS{OVF_NIBBLE}};
            ovf_d   = 1'b1;
            blank_d = '0;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        acc_d = acc_shift;
        bin_d = bin_shift;
        if (cnt_q == '0) begin
          state_d = DONE;
          bcd_d   = acc_shift;
          ovf_d   = 1'b0;
          blank_d = blank_calc;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      blank_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bcd_out    = bcd_q;
  assign ovf        = ovf_q;
  assign blank_mask = blank_q;

endmodule
